mor1kx_gpr_spr_master: RTL and testbench
========================================

// Module: mor1kx_gpr_spr_master
// PURPOSE
//  SPR-bus initiator for GPR access from the debug/control side. Turns single
//  read/write requests for GPR index N into an SPR bus transaction at 0x0400+N
//  (group 0, addr[15:9]==7'h2), waits for the GPR responder's ack, and returns
//  read data or an error. Sits between the debug unit and the shared SPR bus.
// PARAMETERS
//  OPTION_OPERAND_WIDTH      32   data width
//  OPTION_RF_ADDR_WIDTH      5    architectural GPR index width
//  OPTION_RF_WORDS           32   GPRs per context
//  OPTION_RF_NUM_SHADOW_GPR  0    shadow contexts; legal idx < WORDS*(1+SHADOW)
//  IDX_WIDTH                 9    request index width (max 9, fits addr[8:0])
//  TIMEOUT_CYCLES            64   ack timeout in cycles; 0 disables timeout
// PORTS
//  clk              in   1     clock
//  rst              in   1     synchronous reset, active-high
//  req_valid_i      in   1     request present
//  req_ready_o      out  1     request accepted when valid&ready
//  req_we_i         in   1     1=write GPR, 0=read GPR
//  req_idx_i        in   IDX_WIDTH  GPR index (incl. shadow context bits)
//  req_dat_i        in   OW    write data
//  abort_i          in   1     cancel outstanding access, no response
//  rsp_valid_o      out  1     response present
//  rsp_ready_i      in   1     response consumed when valid&ready
//  rsp_err_o        out  1     1=timeout or index out of range
//  rsp_dat_o        out  OW    read data (0 for writes and errors)
//  spr_bus_addr_o   out  16    {7'h2, idx zero-extended to 9 bits}
//  spr_bus_stb_o    out  1     bus strobe
//  spr_bus_we_o     out  1     bus write enable
//  spr_bus_dat_o    out  OW    bus write data
//  spr_gpr_ack_i    in   1     responder ack
//  spr_gpr_dat_i    in   OW    responder read data, valid in ack cycle
// BEHAVIOUR
//  Reset: state IDLE; req_ready_o=1 (only in IDLE), rsp_valid_o=0, rsp_err_o=0,
//   rsp_dat_o=0, spr_bus_stb_o=0, spr_bus_we_o=0, addr/dat=0, timer=0.
//  States: IDLE -> ACCESS -> RESP -> IDLE; IDLE -> RESP directly on bad index.
//  IDLE: req_ready_o=1. On accept, latch we/idx/dat. idx >= WORDS*(1+SHADOW):
//   next state RESP with err=1, dat=0, no bus strobe ever. Else ACCESS.
//  ACCESS: all spr_bus_* outputs registered; stb=1, addr/we/dat held stable
//   for the whole access. timer increments each ACCESS cycle.
//   ack seen: next cycle stb=0, state RESP, err=0, dat=spr_gpr_dat_i if read
//   else 0. Ack is sampled only in ACCESS; acks in other states ignored.
//   TIMEOUT_CYCLES>0 and timer==TIMEOUT_CYCLES-1 w/o ack: stb=0, RESP, err=1.
//   ack and timeout same cycle: ack wins (err=0).
//   abort_i in ACCESS: stb=0 next cycle, state IDLE, no response; abort_i
//   coincident with ack: abort wins, data dropped. abort_i ignored elsewhere.
//  RESP: rsp_valid_o=1, rsp_* stable until rsp_ready_i; then IDLE next cycle.
//   req_ready_o=0 in RESP (one outstanding transaction max).
//  Minimum latency: accept at T, stb at T+1, ack at T+k (k>=1), rsp_valid at
//   T+k+1. Back-to-back: next accept no earlier than cycle after rsp handshake.
//  rst mid-ACCESS: stb=0 the following cycle, transaction dropped.
// TESTING
//  read idx=3, ack at 2nd stb cycle w/ dat 0xDEADBEEF -> addr 0x0403, we=0,
//   rsp_valid 1 cycle after ack, dat=0xDEADBEEF, err=0.
//  write idx=31 dat=0x12345678, ack held off 3 cycles -> stb/addr 0x041F/dat
//   stable 4 cycles, rsp dat=0, err=0.
//  TIMEOUT_CYCLES=16, no ack -> stb high exactly 16 cycles, rsp err=1, dat=0.
//  idx=40, WORDS=32, SHADOW=0 -> rsp err=1 at accept+1, stb never asserted.
//  abort_i 2 cycles into read; later read idx=5 -> no rsp for first, second
//   completes normally with addr 0x0405.
//  rsp_ready_i low 5 cycles -> rsp held stable, req_ready_o=0; rst in ACCESS
//   -> stb=0 next cycle, rsp_valid never asserted.

Source files
------------

// File: rtl/mor1kx_gpr_spr_master.sv
// SPR-bus initiator for debug-side GPR access: one request in flight, mapped to
// SPR address 0x0400+idx, with ack timeout, abort and bad-index error response.
module mor1kx_gpr_spr_master #(
    parameter int OPTION_OPERAND_WIDTH     = 32,
    parameter int OPTION_RF_ADDR_WIDTH     = 5,
    parameter int OPTION_RF_WORDS          = 32,
    parameter int OPTION_RF_NUM_SHADOW_GPR = 0,
    parameter int IDX_WIDTH                = 9,
    parameter int TIMEOUT_CYCLES           = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic                            req_we_i,
    input  logic [IDX_WIDTH-1:0]            req_idx_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] req_dat_i,
    input  logic                            abort_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic                            rsp_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] rsp_dat_o,
    output logic [15:0]                     spr_bus_addr_o,
    output logic                            spr_bus_stb_o,
    output logic                            spr_bus_we_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_o,
    input  logic                            spr_gpr_ack_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_i
);

    localparam int OW = OPTION_OPERAND_WIDTH;
    // A context can never hold more words than its register index can name.
    localparam int unsigned CTX_WORDS =
        (OPTION_RF_WORDS < (1 << OPTION_RF_ADDR_WIDTH)) ? OPTION_RF_WORDS
                                                        : (1 << OPTION_RF_ADDR_WIDTH);
    localparam int unsigned IDX_LIMIT = CTX_WORDS * (1 + OPTION_RF_NUM_SHADOW_GPR);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t          state_q;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic            rsp_err_q;
    logic [OW-1:0]   rsp_dat_q;
    logic [15:0]     addr_q;
    logic            stb_q;
    logic            we_q;
    logic [OW-1:0]   bus_dat_q;
    logic [TW-1:0]   timer_q;

    logic            idx_legal_d;
    logic            timeout_hit_d;

    // Decode index legality and the last permitted ACCESS cycle.
    always_comb begin
        idx_legal_d = (32'(req_idx_i) < IDX_LIMIT);
        if (TIMEOUT_CYCLES > 0) begin
            timeout_hit_d = (timer_q == TO_LAST);
        end else begin
            timeout_hit_d = 1'b0;
        end
    end

    // Transaction FSM with all handshake and bus outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
            addr_q      <= '0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            bus_dat_q   <= '0;
            timer_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        req_ready_q <= 1'b0;
                        timer_q     <= '0;
                        if (idx_legal_d) begin
                            state_q   <= ST_ACCESS;
                            stb_q     <= 1'b1;
                            we_q      <= req_we_i;
                            addr_q    <= {7'h02, 9'(req_idx_i)};
                            bus_dat_q <= req_dat_i;
                        end else begin
                            // Out-of-range index answers immediately, bus untouched.
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_dat_q   <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (abort_i) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                        stb_q       <= 1'b0;
                        we_q        <= 1'b0;
                        addr_q      <= '0;
                        bus_dat_q   <= '0;
                    end else if (spr_gpr_ack_i) begin
                        state_q     <= ST_RESP;
                        stb_q       <= 1'b0;
                        we_q        <= 1'b0;
                        addr_q      <= '0;
                        bus_dat_q   <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_dat_q   <= we_q ? '0 : spr_gpr_dat_i;
                    end else if (timeout_hit_d) begin
                        state_q     <= ST_RESP;
                        stb_q       <= 1'b0;
                        we_q        <= 1'b0;
                        addr_q      <= '0;
                        bus_dat_q   <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_dat_q   <= '0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_dat_q   <= '0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_dat_q   <= '0;
                    stb_q       <= 1'b0;
                    we_q        <= 1'b0;
                    addr_q      <= '0;
                    bus_dat_q   <= '0;
                end
            endcase
        end
    end

    assign req_ready_o    = req_ready_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_err_o      = rsp_err_q;
    assign rsp_dat_o      = rsp_dat_q;
    assign spr_bus_addr_o = addr_q;
    assign spr_bus_stb_o  = stb_q;
    assign spr_bus_we_o   = we_q;
    assign spr_bus_dat_o  = bus_dat_q;

endmodule

// File: tb/tb_mor1kx_gpr_spr_master.sv
// Scoreboard bench for mor1kx_gpr_spr_master: directed requests push expected
// responses; a negedge monitor pops and compares on every response handshake.
module tb_mor1kx_gpr_spr_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [8:0]  req_idx_i;
    logic [31:0] req_dat_i;
    logic        abort_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic        rsp_err_o;
    logic [31:0] rsp_dat_o;
    logic [15:0] spr_bus_addr_o;
    logic        spr_bus_stb_o;
    logic        spr_bus_we_o;
    logic [31:0] spr_bus_dat_o;
    logic        spr_gpr_ack_i;
    logic [31:0] spr_gpr_dat_i;

    int vectors = 0;
    int miscompares = 0;
    logic [32:0] exp_q[$];

    mor1kx_gpr_spr_master #(
        .OPTION_OPERAND_WIDTH(32),
        .OPTION_RF_ADDR_WIDTH(5),
        .OPTION_RF_WORDS(32),
        .OPTION_RF_NUM_SHADOW_GPR(0),
        .IDX_WIDTH(9),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_idx_i(req_idx_i), .req_dat_i(req_dat_i),
        .abort_i(abort_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_err_o(rsp_err_o), .rsp_dat_o(rsp_dat_o),
        .spr_bus_addr_o(spr_bus_addr_o), .spr_bus_stb_o(spr_bus_stb_o),
        .spr_bus_we_o(spr_bus_we_o), .spr_bus_dat_o(spr_bus_dat_o),
        .spr_gpr_ack_i(spr_gpr_ack_i), .spr_gpr_dat_i(spr_gpr_dat_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change 2 time units after the active edge; outputs are settled then.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic we, input logic [8:0] idx, input logic [31:0] dat);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_idx_i   = idx;
        req_dat_i   = dat;
        step();
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_dat_i   = 32'h0;
    endtask

    // Response monitor: every handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && rsp_valid_o && rsp_ready_i) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_unexpected: got err=%0b dat=0x%08h expected no response",
                         rsp_err_o, rsp_dat_o);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({rsp_err_o, rsp_dat_o} !== e) begin
                    miscompares++;
                    $display("FAIL rsp_data: got err=%0b dat=0x%08h expected err=%0b dat=0x%08h",
                             rsp_err_o, rsp_dat_o, e[32], e[31:0]);
                end
            end
        end
    end

    initial begin
        int cnt;
        rst = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_idx_i = 9'd0;
        req_dat_i = 32'h0; abort_i = 1'b0; rsp_ready_i = 1'b1;
        spr_gpr_ack_i = 1'b0; spr_gpr_dat_i = 32'h0;
        step(); step();
        chk("reset_req_ready", 32'(req_ready_o), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("reset_stb", 32'(spr_bus_stb_o), 32'd0);
        chk("reset_addr", 32'(spr_bus_addr_o), 32'h0);
        rst = 1'b0;
        step();

        // Read idx 3, ack in second strobe cycle.
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        issue(1'b0, 9'd3, 32'h0);
        chk("rd_stb", 32'(spr_bus_stb_o), 32'd1);
        chk("rd_addr", 32'(spr_bus_addr_o), 32'h0403);
        chk("rd_we", 32'(spr_bus_we_o), 32'd0);
        chk("rd_req_ready", 32'(req_ready_o), 32'd0);
        step();
        chk("rd_stb2", 32'(spr_bus_stb_o), 32'd1);
        spr_gpr_ack_i = 1'b1; spr_gpr_dat_i = 32'hDEADBEEF;
        step();
        spr_gpr_ack_i = 1'b0; spr_gpr_dat_i = 32'h0;
        chk("rd_stb_drop", 32'(spr_bus_stb_o), 32'd0);
        chk("rd_rsp_valid", 32'(rsp_valid_o), 32'd1);
        step();
        chk("rd_back_idle", 32'(req_ready_o), 32'd1);

        // Write idx 31, ack held off three cycles.
        exp_q.push_back({1'b0, 32'h0});
        issue(1'b1, 9'd31, 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            chk("wr_stb", 32'(spr_bus_stb_o), 32'd1);
            chk("wr_addr", 32'(spr_bus_addr_o), 32'h041F);
            chk("wr_dat", spr_bus_dat_o, 32'h12345678);
            chk("wr_we", 32'(spr_bus_we_o), 32'd1);
            if (i == 3) spr_gpr_ack_i = 1'b1;
            spr_gpr_dat_i = 32'hCAFE0000 + 32'(i);
            step();
        end
        spr_gpr_ack_i = 1'b0;
        chk("wr_stb_drop", 32'(spr_bus_stb_o), 32'd0);
        chk("wr_rsp_valid", 32'(rsp_valid_o), 32'd1);
        step();

        // No ack: strobe lasts exactly TIMEOUT_CYCLES cycles.
        exp_q.push_back({1'b1, 32'h0});
        issue(1'b0, 9'd7, 32'h0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!spr_bus_stb_o) break;
            cnt++;
            step();
        end
        chk("to_stb_cycles", 32'(cnt), 32'd16);
        chk("to_rsp_valid", 32'(rsp_valid_o), 32'd1);
        step();

        // Out-of-range index: error one cycle after accept, no strobe.
        exp_q.push_back({1'b1, 32'h0});
        issue(1'b0, 9'd40, 32'h0);
        chk("bad_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("bad_rsp_err", 32'(rsp_err_o), 32'd1);
        chk("bad_stb", 32'(spr_bus_stb_o), 32'd0);
        step();
        chk("bad_stb_after", 32'(spr_bus_stb_o), 32'd0);

        // Abort two cycles in, coincident with ack: no response.
        issue(1'b0, 9'd9, 32'h0);
        step();
        abort_i = 1'b1; spr_gpr_ack_i = 1'b1; spr_gpr_dat_i = 32'h99999999;
        step();
        abort_i = 1'b0; spr_gpr_ack_i = 1'b0; spr_gpr_dat_i = 32'h0;
        chk("ab_stb", 32'(spr_bus_stb_o), 32'd0);
        chk("ab_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("ab_req_ready", 32'(req_ready_o), 32'd1);
        exp_q.push_back({1'b0, 32'hA5A50005});
        issue(1'b0, 9'd5, 32'h0);
        chk("ab2_addr", 32'(spr_bus_addr_o), 32'h0405);
        spr_gpr_ack_i = 1'b1; spr_gpr_dat_i = 32'hA5A50005;
        step();
        spr_gpr_ack_i = 1'b0; spr_gpr_dat_i = 32'h0;
        chk("ab2_rsp_valid", 32'(rsp_valid_o), 32'd1);
        step();

        // Response back-pressure for five cycles.
        rsp_ready_i = 1'b0;
        exp_q.push_back({1'b0, 32'h00001111});
        issue(1'b0, 9'd1, 32'h0);
        spr_gpr_ack_i = 1'b1; spr_gpr_dat_i = 32'h00001111;
        step();
        spr_gpr_ack_i = 1'b0; spr_gpr_dat_i = 32'hFFFF0000;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
            chk("bp_rsp_dat", rsp_dat_o, 32'h00001111);
            chk("bp_req_ready", 32'(req_ready_o), 32'd0);
            step();
        end
        rsp_ready_i = 1'b1;
        step();
        chk("bp_released", 32'(rsp_valid_o), 32'd0);
        chk("bp_req_ready_back", 32'(req_ready_o), 32'd1);

        // Reset mid-access drops the transaction.
        issue(1'b0, 9'd2, 32'h0);
        chk("rs_stb_before", 32'(spr_bus_stb_o), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs_stb", 32'(spr_bus_stb_o), 32'd0);
        chk("rs_rsp_valid", 32'(rsp_valid_o), 32'd0);
        spr_gpr_ack_i = 1'b1;
        step();
        spr_gpr_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rs_no_rsp", 32'(rsp_valid_o), 32'd0);
            step();
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
